// File: rtl/wb_stage.sv
// Writeback stage: picks the retiring result, aligns load data, and drives the
// register-file write port and forwarding path from a one-cycle commit slot.
module wb_stage #(
  parameter int XLEN = 32,
  parameter int GPRN = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$clog2(GPRN)-1:0] in_rd,
  input  logic                    in_rd_we,
  input  logic [1:0]              in_sel,
  input  logic [XLEN-1:0]         in_alu_res,
  input  logic [XLEN-1:0]         in_pc4,
  input  logic [2:0]              in_ld_funct3,
  input  logic [1:0]              in_ld_addr_lo,
  input  logic                    dmem_rvalid,
  input  logic [XLEN-1:0]         dmem_rdata,
  output logic                    gpr_we,
  output logic                    gpr_en,
  output logic [$clog2(GPRN)-1:0] gpr_addr_rd,
  output logic [XLEN-1:0]         gpr_data_rd,
  output logic                    fwd_valid,
  output logic [$clog2(GPRN)-1:0] fwd_rd,
  output logic [XLEN-1:0]         fwd_data,
  output logic                    ld_pending,
  output logic [$clog2(GPRN)-1:0] ld_rd,
  output logic                    exc_load,
  output logic [XLEN-1:0]         instret
);

  localparam int AW = $clog2(GPRN);

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    S_IDLE,
    S_WAIT_LD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Fields of the load waiting for its data beat.
  logic [AW-1:0] r_ld_rd;
  logic          r_ld_we;
  logic [2:0]    r_ld_f3;
  logic [1:0]    r_ld_lo;

  // Commit slot.
  logic            r_cv;
  logic [AW-1:0]   r_rd;
  logic            r_rd_we;
  logic [XLEN-1:0] r_data;
  logic            r_fault;

  logic            r_gpr_en;
  logic [XLEN-1:0] r_instret;

  logic            w_commit;
  logic            w_latch;
  logic [AW-1:0]   w_cm_rd;
  logic            w_cm_we;
  logic [XLEN-1:0] w_cm_data;
  logic            w_cm_fault;

  logic [7:0]      w_ld_byte;
  logic [15:0]     w_ld_half;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_fault;

  assign w_ld_byte = dmem_rdata[8*r_ld_lo +: 8];
  assign w_ld_half = r_ld_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    w_ld_data  = '0;
    w_ld_fault = 1'b1;
    case (r_ld_f3)
      F3_LB: begin
        w_ld_data  = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
        w_ld_fault = 1'b0;
      end
      F3_LBU: begin
        w_ld_data  = {{(XLEN-8){1'b0}}, w_ld_byte};
        w_ld_fault = 1'b0;
      end
      F3_LH: begin
        w_ld_data  = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
        w_ld_fault = r_ld_lo[0];
      end
      F3_LHU: begin
        w_ld_data  = {{(XLEN-16){1'b0}}, w_ld_half};
        w_ld_fault = r_ld_lo[0];
      end
      F3_LW: begin
        w_ld_data  = dmem_rdata;
        w_ld_fault = (r_ld_lo != 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_latch     = 1'b0;
    w_cm_rd     = in_rd;
    w_cm_we     = in_rd_we;
    w_cm_data   = in_alu_res;
    w_cm_fault  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (in_sel == SEL_LOAD) begin
            w_latch     = 1'b1;
            w_state_nxt = S_WAIT_LD;
          end else begin
            w_commit  = 1'b1;
            w_cm_data = (in_sel == SEL_PC4) ? in_pc4 : in_alu_res;
          end
        end
      end
      S_WAIT_LD: begin
        if (dmem_rvalid) begin
          w_commit    = 1'b1;
          w_cm_rd     = r_ld_rd;
          w_cm_we     = r_ld_we;
          w_cm_data   = w_ld_data;
          w_cm_fault  = w_ld_fault;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every register, including the latched load fields, is cleared on reset so
  // a reset mid-load leaves nothing stale behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ld_rd   <= '0;
      r_ld_we   <= 1'b0;
      r_ld_f3   <= '0;
      r_ld_lo   <= '0;
      r_cv      <= 1'b0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_data    <= '0;
      r_fault   <= 1'b0;
      r_gpr_en  <= 1'b0;
      r_instret <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_state_nxt;
      r_gpr_en <= 1'b1;
      r_cv     <= w_commit;
      if (w_latch) begin
        r_ld_rd <= in_rd;
        r_ld_we <= in_rd_we;
        r_ld_f3 <= in_ld_funct3;
        r_ld_lo <= in_ld_addr_lo;
      end
      if (w_commit) begin
        r_rd      <= w_cm_rd;
        r_rd_we   <= w_cm_we;
        r_data    <= w_cm_data;
        r_fault   <= w_cm_fault;
        r_instret <= r_instret + XLEN'(1);
      end
    end
  end

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign gpr_we      = r_cv && r_rd_we && (r_rd != '0) && !r_fault;
  assign gpr_en      = r_gpr_en;
  assign gpr_addr_rd = r_rd;
  assign gpr_data_rd = r_data;
  assign fwd_valid   = gpr_we;
  assign fwd_rd      = r_rd;
  assign fwd_data    = r_data;
  assign ld_pending  = (r_state == S_WAIT_LD);
  assign ld_rd       = ld_pending ? r_ld_rd : '0;
  assign exc_load    = r_cv && r_fault;
  assign instret     = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal expectations plus a random
// stream, all checked every cycle against a transaction-level model.
module tb_wb_stage;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, in_rd_we;
  logic [4:0]  in_rd;
  logic [1:0]  in_sel;
  logic [31:0] in_alu_res, in_pc4;
  logic [2:0]  in_ld_funct3;
  logic [1:0]  in_ld_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        gpr_we, gpr_en, fwd_valid, ld_pending, exc_load;
  logic [4:0]  gpr_addr_rd, fwd_rd, ld_rd;
  logic [31:0] gpr_data_rd, fwd_data, instret;

  wb_stage #(.XLEN(32), .GPRN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_sel(in_sel), .in_alu_res(in_alu_res), .in_pc4(in_pc4),
    .in_ld_funct3(in_ld_funct3), .in_ld_addr_lo(in_ld_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .gpr_we(gpr_we), .gpr_en(gpr_en), .gpr_addr_rd(gpr_addr_rd), .gpr_data_rd(gpr_data_rd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .ld_pending(ld_pending), .ld_rd(ld_rd), .exc_load(exc_load), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_pend, m_p_we, m_en;
  logic [4:0]  m_p_rd;
  logic [2:0]  m_p_f3;
  logic [1:0]  m_p_lo;
  bit          e_cv, e_rdwe, e_fault;
  logic [4:0]  e_rd;
  logic [31:0] e_data, m_instret;

  function automatic logic [31:0] ld_value(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(lo))) & 32'h0000_00FF;
    h = (w >> (lo[1] ? 16 : 0)) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'h80)   ? b - 32'h100   : b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ld_fault(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return lo[0];
      3'd2:       return lo != 2'd0;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_en = 0; m_instret = 0;
    e_cv = 0; e_rdwe = 0; e_fault = 0; e_rd = 0; e_data = 0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_en = 1;
      e_cv = 0;
      if (!m_pend) begin
        if (in_valid) begin
          if (in_sel == SEL_LOAD) begin
            m_pend = 1; m_p_rd = in_rd; m_p_we = in_rd_we;
            m_p_f3 = in_ld_funct3; m_p_lo = in_ld_addr_lo;
          end else begin
            e_cv = 1; e_rd = in_rd; e_rdwe = in_rd_we; e_fault = 0;
            e_data = (in_sel == SEL_PC4) ? in_pc4 : in_alu_res;
          end
        end
      end else if (dmem_rvalid) begin
        e_cv = 1; e_rd = m_p_rd; e_rdwe = m_p_we;
        e_data  = ld_value(m_p_f3, m_p_lo, dmem_rdata);
        e_fault = ld_fault(m_p_f3, m_p_lo);
        m_pend  = 0;
      end
      if (e_cv) m_instret = m_instret + 32'd1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic want_we;
  always @(negedge clk) begin
    want_we = e_cv && e_rdwe && (e_rd != 5'd0) && !e_fault;
    check("in_ready",   32'(in_ready),   32'(!rst && !m_pend));
    check("gpr_we",     32'(gpr_we),     32'(want_we));
    check("fwd_valid",  32'(fwd_valid),  32'(want_we));
    check("gpr_en",     32'(gpr_en),     32'(m_en));
    check("exc_load",   32'(exc_load),   32'(e_cv && e_fault));
    check("ld_pending", 32'(ld_pending), 32'(m_pend));
    check("ld_rd",      32'(ld_rd),      32'(m_pend ? m_p_rd : 5'd0));
    check("instret",    instret,         m_instret);
    if (want_we || rst) begin
      check("gpr_addr_rd", 32'(gpr_addr_rd), 32'(e_rd));
      check("gpr_data_rd", gpr_data_rd,      e_data);
      check("fwd_rd",      32'(fwd_rd),      32'(e_rd));
      check("fwd_data",    fwd_data,         e_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                      input logic [31:0] pc4, input logic [2:0] f3, input logic [1:0] lo);
    in_valid = 1'b1; in_rd = rd; in_rd_we = 1'b1; in_sel = sel;
    in_alu_res = alu; in_pc4 = pc4; in_ld_funct3 = f3; in_ld_addr_lo = lo;
  endtask

  task automatic load_test(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] rdata, input string tag);
    send(rd, SEL_LOAD, 32'hDEAD_BEEF, 32'hCAFE_0000, f3, lo);
    tick();
    in_valid = 1'b0;
    check({tag, "_wait_ready"},   32'(in_ready),   32'd0);
    check({tag, "_wait_pending"}, 32'(ld_pending), 32'd1);
    check({tag, "_wait_ld_rd"},   32'(ld_rd),      32'(rd));
    tick();
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    in_valid = 0; in_rd = 0; in_rd_we = 0; in_sel = 0; in_alu_res = 0; in_pc4 = 0;
    in_ld_funct3 = 0; in_ld_addr_lo = 0; dmem_rvalid = 0; dmem_rdata = 0;
    #1;
    rst = 1'b1;
    model_reset();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_gpr_en",   32'(gpr_en),   32'd0);
    check("rst_instret",  instret,       32'd0);
    tick();
    rst = 1'b0;

    // ALU stream, back to back
    send(5'd5, SEL_ALU, 32'h0000_1234, 32'h0, 3'd0, 2'd0);
    tick();
    send(5'd6, SEL_ALU, 32'h0000_ABCD, 32'h0, 3'd0, 2'd0);
    check("alu0_we",   32'(gpr_we),      32'd1);
    check("alu0_addr", 32'(gpr_addr_rd), 32'd5);
    check("alu0_data", gpr_data_rd,      32'h0000_1234);
    check("alu0_en",   32'(gpr_en),      32'd1);
    tick();
    in_valid = 1'b0;
    check("alu1_we",      32'(gpr_we),      32'd1);
    check("alu1_addr",    32'(gpr_addr_rd), 32'd6);
    check("alu1_data",    gpr_data_rd,      32'h0000_ABCD);
    check("alu1_instret", instret,          32'd2);
    tick();
    check("alu_done_we", 32'(gpr_we), 32'd0);

    // LB / LBU from byte 2 of 0x11802233
    load_test(5'd9, 3'd0, 2'd2, 32'h1180_2233, "lb");
    check("lb_we",    32'(gpr_we), 32'd1);
    check("lb_data",  gpr_data_rd, 32'hFFFF_FF80);
    check("lb_ready", 32'(in_ready), 32'd1);
    tick();
    load_test(5'd9, 3'd4, 2'd2, 32'h1180_2233, "lbu");
    check("lbu_data", gpr_data_rd, 32'h0000_0080);
    check("lbu_instret", instret, 32'd4);
    tick();

    // misaligned LW
    send(5'd7, SEL_LOAD, 32'h0, 32'h0, 3'd2, 2'd1);
    tick();
    in_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    tick();
    dmem_rvalid = 1'b0;
    check("mis_we",      32'(gpr_we),   32'd0);
    check("mis_exc",     32'(exc_load), 32'd1);
    check("mis_instret", instret,       32'd5);
    tick();
    check("mis_exc_once", 32'(exc_load), 32'd0);

    // PC4 link to x0, then to x1
    send(5'd0, SEL_PC4, 32'hDEAD_0000, 32'h0000_0100, 3'd0, 2'd0);
    tick();
    send(5'd1, SEL_PC4, 32'hDEAD_0000, 32'h0000_0100, 3'd0, 2'd0);
    check("x0_we", 32'(gpr_we), 32'd0);
    tick();
    in_valid = 1'b0;
    check("pc4_we",   32'(gpr_we),      32'd1);
    check("pc4_addr", 32'(gpr_addr_rd), 32'd1);
    check("pc4_data", gpr_data_rd,      32'h0000_0100);

    // stray rvalid in idle
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    check("stray_we",      32'(gpr_we),   32'd0);
    check("stray_exc",     32'(exc_load), 32'd0);
    check("stray_instret", instret,       32'd7);

    // reset in the middle of a load, late rvalid afterwards
    send(5'd12, SEL_LOAD, 32'h0, 32'h0, 3'd2, 2'd0);
    tick();
    in_valid = 1'b0;
    check("rml_pending", 32'(ld_pending), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    check("rml_pending_clr", 32'(ld_pending), 32'd0);
    check("rml_ld_rd",       32'(ld_rd),      32'd0);
    check("rml_instret",     instret,         32'd0);
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    check("late_we",   32'(gpr_we),      32'd0);
    check("late_exc",  32'(exc_load),    32'd0);
    check("late_addr", 32'(gpr_addr_rd), 32'd0);
    check("late_data", gpr_data_rd,      32'd0);
    check("late_fwd",  32'(fwd_valid),   32'd0);
    check("late_cnt",  instret,          32'd0);

    // instret wrap from a forced all-ones count
    force dut.r_instret = 32'hFFFF_FFFF;
    m_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    check("wrap_pre", instret, 32'hFFFF_FFFF);
    send(5'd3, SEL_ALU, 32'h0000_0042, 32'h0, 3'd0, 2'd0);
    tick();
    in_valid = 1'b0;
    check("wrap_cnt", instret,     32'd0);
    check("wrap_we",  32'(gpr_we), 32'd1);
    tick();

    // random stream against the model
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 499) == 0);
      if (rst) model_reset();
      in_valid      = ($urandom_range(0, 9) < 7);
      in_rd         = 5'($urandom);
      in_rd_we      = 1'($urandom);
      in_sel        = 2'($urandom);
      in_alu_res    = $urandom;
      in_pc4        = $urandom;
      in_ld_funct3  = 3'($urandom);
      in_ld_addr_lo = 2'($urandom);
      dmem_rdata    = $urandom;
      dmem_rvalid   = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; dmem_rvalid = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32I core, directly upstream of the register file. Accepts one retiring instruction per cycle from the memory stage, selects its result (ALU, PC+4, or load data), aligns and sign-extends load data returned by data memory, and drives the register file write port from a registered commit slot. It also exports forwarding and load-pending information for hazard logic and counts retired instructions.

## Interface
- XLEN, 32, datapath width
- GPRN, 32, number of architectural registers; register address width is $clog2(GPRN)
- clk  in  1  core clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage accepts when in_valid & in_ready at the rising edge
- in_rd  in  5  destination register
- in_rd_we  in  1  instruction writes rd
- in_sel  in  2  result source: 00 ALU, 01 LOAD, 10 PC4, 11 reserved (treated as ALU)
- in_alu_res  in  32  ALU result
- in_pc4  in  32  PC+4 (JAL/JALR link value)
- in_ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_ld_addr_lo  in  2  byte offset of the load address
- dmem_rvalid  in  1  load data valid, one-cycle pulse
- dmem_rdata  in  32  aligned 32-bit word containing the load data
- gpr_we, gpr_en  out  1 each  register-file write enable / global enable
- gpr_addr_rd  out  5  write address
- gpr_data_rd  out  32  write data
- fwd_valid  out  1  equals gpr_we; fwd_rd, fwd_data mirror gpr_addr_rd, gpr_data_rd
- fwd_rd  out  5, fwd_data  out  32
- ld_pending  out  1  a load is waiting for dmem_rvalid
- ld_rd  out  5  destination of the pending load
- exc_load  out  1  one-cycle pulse: committed load was misaligned or had illegal funct3
- instret  out  32  retired-instruction count

## Operation
- FSM states: IDLE, WAIT_LD. Reset state IDLE.
- in_ready = 1 in IDLE, 0 in WAIT_LD.
- IDLE, accept with in_sel != LOAD: commit slot loads {rd, rd_we, result} and is valid next cycle; stay IDLE.
- IDLE, accept with in_sel = LOAD: latch rd, rd_we, funct3, addr_lo; go to WAIT_LD; commit slot invalid next cycle.
- WAIT_LD, dmem_rvalid = 1: extract data and load commit slot; go to IDLE. Without rvalid: stay, holding all latched fields.
- dmem_rvalid in IDLE is ignored; it does not create a commit and does not raise exc_load.
- Extraction: LB/LBU select byte dmem_rdata[8*addr_lo +: 8]; LH/LHU select halfword at addr_lo[1]; LW whole word. LB/LH sign-extend; LBU/LHU zero-extend.
- Load fault: LH/LHU with addr_lo[0] = 1, LW with addr_lo != 0, or funct3 in {011, 110, 111}. Commit happens, but the write is suppressed and exc_load pulses in the commit cycle.
- gpr_we = commit_valid & rd_we & (rd != 0) & !fault. x0 is never written.
- gpr_en is a register: 0 in reset, 1 from the first clock edge after rst deasserts.
- instret increments by 1 on every commit, including suppressed writes and faults; it wraps 0xFFFFFFFF -> 0.
- ld_pending = (state == WAIT_LD). ld_rd holds the latched rd, or 0 when not pending.

## Timing
- Reset values: in_ready 0 while rst is high, then 1. gpr_we 0, gpr_en 0, gpr_addr_rd 0, gpr_data_rd 0, all fwd_* 0, ld_pending 0, ld_rd 0, exc_load 0, instret 0.
- Non-load latency: accepted at edge N, gpr_we high during cycle N..N+1, write lands in the GPR at edge N+1. Throughput is 1 per cycle.
- Load latency: accepted at edge N. The earliest valid rvalid is sampled at edge N+1; the commit is visible the cycle after rvalid is sampled. The next instruction can be accepted at the edge after rvalid.
- The commit slot is valid for exactly one cycle per instruction. Back-to-back commits to the same rd produce two consecutive write pulses.
- Reset mid-load: asserting rst in WAIT_LD returns the stage to IDLE immediately and drops the commit slot. A late rvalid that arrives afterwards is ignored.

## Test plan
- ALU stream: accept rd=5, alu=0x1234 then rd=6, alu=0xABCD on consecutive cycles -> gpr_we high for 2 cycles with (5, 0x1234) then (6, 0xABCD); instret = 2.
- LB sign-extend: LB, addr_lo=2, rvalid 3 cycles after accept with rdata 0x11802233 -> in_ready 0 and ld_pending 1 while waiting; commit data 0xFFFFFF80; LBU with the same stimulus -> 0x00000080.
- Misaligned LW: addr_lo=1, rd=7 -> gpr_we stays 0, exc_load pulses once, instret increments.
- x0 and PC4: JAL-style commit with rd=0, pc4=0x100 -> no write; with rd=1 -> write (1, 0x00000100).
- Stray rvalid and reset mid-load: rvalid pulse in IDLE -> no commit. Assert rst in WAIT_LD, deassert, then send rvalid -> no commit; all outputs at their reset values.
- instret wrap: preload the count via 2^32-1 commits (or a forced value) plus 1 more -> instret = 0.
